cond_logic: RTL

Condition and flag unit that sits directly downstream of the ALU. Latches the ALU's `{N,Z,C,V}` flags into an architectural flag register and evaluates the 4-bit instruction condition field against the stored flags. Gates the register-write, memory-write and PC-select strobes from the decoder so that a failed condition makes the instruction a no-op. Optionally tracks an IT-style predication block of up to four instructions.

---
 rtl/cond_logic.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/cond_logic.sv
// ---------------------------------------------------------------------------
// cond_logic
//
// Condition and flag unit sitting directly behind the ALU. Holds the
// architectural {N,Z,C,V} flag register, evaluates the instruction condition
// field against the stored flags and gates the decoder's write strobes so a
// failed condition turns the instruction into a no-op. An optional IT-style
// predication block of up to four instructions is compiled in when the macro
// COND_IT_EN is defined. Without it, the IT inputs are ignored and the IT
// outputs are tied low.
//
// Ports
//   clk          in  1  single clock, rising edge
//   reset        in  1  synchronous, active high
//   instr_valid  in  1  instruction present in execute this cycle
//   cond         in  4  condition field of the current instruction
//   alu_flags    in  4  {N,Z,C,V} from the ALU, current cycle
//   flag_w       in  2  bit1 writes N,Z; bit0 writes C,V
//   pc_s         in  1  decoder PC-write request
//   reg_w        in  1  decoder register-write request
//   mem_w        in  1  decoder memory-write request
//   it_start     in  1  current instruction is an IT setup
//   it_cond      in  4  IT block base condition
//   it_len       in  3  IT block length, legal 1..4
//   it_mask      in  4  then(1)/else(0) selector per slot
//   pc_src       out 1  gated pc_s
//   reg_write    out 1  gated reg_w
//   mem_write    out 1  gated mem_w
//   flags        out 4  architectural {N,Z,C,V}
//   cond_ex      out 1  combinational condition result
//   cond_ex_q    out 1  cond_ex captured on valid cycles
//   it_active    out 1  IT block in progress
//   it_err       out 1  one-cycle pulse after an illegal IT request
//
// IT state machine (COND_IT_EN)
//   state  | meaning
//   IDLE   | no block; effective condition is the cond input
//   ACTIVE | block in progress; condition comes from it_cond_q/mask_q[slot]
// ---------------------------------------------------------------------------
module cond_logic (
   input  logic       clk,
   input  logic       reset,
   input  logic       instr_valid,
   input  logic [3:0] cond,
   input  logic [3:0] alu_flags,
   input  logic [1:0] flag_w,
   input  logic       pc_s,
   input  logic       reg_w,
   input  logic       mem_w,
   input  logic       it_start,
   input  logic [3:0] it_cond,
   input  logic [2:0] it_len,
   input  logic [3:0] it_mask,
   output logic       pc_src,
   output logic       reg_write,
   output logic       mem_write,
   output logic [3:0] flags,
   output logic       cond_ex,
   output logic       cond_ex_q,
   output logic       it_active,
   output logic       it_err
);

   // Evaluate a 4-bit condition code against {N,Z,C,V}.
   function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, res;
      n  = f[3];
      z  = f[2];
      cy = f[1];
      v  = f[0];
      case (c)
         4'b0000: res = z;
         4'b0001: res = ~z;
         4'b0010: res = cy;
         4'b0011: res = ~cy;
         4'b0100: res = n;
         4'b0101: res = ~n;
         4'b0110: res = v;
         4'b0111: res = ~v;
         4'b1000: res = cy & ~z;
         4'b1001: res = ~cy | z;
         4'b1010: res = (n == v);
         4'b1011: res = (n != v);
         4'b1100: res = ~z & (n == v);
         4'b1101: res = z | (n != v);
         default: res = 1'b1;
      endcase
      return res;
   endfunction

   logic [3:0] flags_q, flags_d;
   logic       cond_ex_d;
   logic [3:0] ce;

`ifdef COND_IT_EN
   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } it_state_e;

   it_state_e  state_q, state_d;
   logic [3:0] it_cond_q, it_cond_d;
   logic [3:0] mask_q, mask_d;
   logic [2:0] remaining_q, remaining_d;
   logic [1:0] slot_q, slot_d;
   logic       it_err_q, it_err_d;
   logic       it_len_ok;

   // Else-slots invert the low bit of the base condition, which flips it to
   // its complementary code.
   always_comb begin
      ce = cond;
      if (state_q == ACTIVE) begin
         ce = {it_cond_q[3:1], it_cond_q[0] ^ ~mask_q[slot_q]};
      end
   end

   assign it_len_ok = (it_len != 3'd0) && (it_len <= 3'd4);

   always_comb begin
      state_d     = state_q;
      it_cond_d   = it_cond_q;
      mask_d      = mask_q;
      remaining_d = remaining_q;
      slot_d      = slot_q;
      it_err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            // A setup instruction whose own condition fails is a no-op and
            // therefore neither opens a block nor raises an error.
            if (instr_valid && it_start && cond_ex) begin
               if (it_len_ok) begin
                  state_d     = ACTIVE;
                  it_cond_d   = it_cond;
                  mask_d      = it_mask;
                  remaining_d = it_len;
                  slot_d      = 2'd0;
               end else begin
                  it_err_d = 1'b1;
               end
            end
         end
         ACTIVE: begin
            // Every valid instruction consumes a slot, pass or fail; a nested
            // it_start is just an ordinary slot occupant plus an error pulse.
            if (instr_valid) begin
               it_err_d = it_start;
               if (remaining_q == 3'd1) begin
                  state_d     = IDLE;
                  remaining_d = 3'd0;
                  slot_d      = 2'd0;
               end else begin
                  remaining_d = remaining_q - 3'd1;
                  slot_d      = slot_q + 2'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         it_cond_q   <= 4'd0;
         mask_q      <= 4'd0;
         remaining_q <= 3'd0;
         slot_q      <= 2'd0;
         it_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         it_cond_q   <= it_cond_d;
         mask_q      <= mask_d;
         remaining_q <= remaining_d;
         slot_q      <= slot_d;
         it_err_q    <= it_err_d;
      end
   end

   assign it_active = (state_q == ACTIVE);
   assign it_err    = it_err_q;
`else
   logic unused_it_inputs;

   assign ce               = cond;
   assign it_active        = 1'b0;
   assign it_err           = 1'b0;
   assign unused_it_inputs = ^{it_start, it_cond, it_len, it_mask};
`endif

   // Evaluation uses the stored flags only; no same-cycle forwarding.
   assign cond_ex   = instr_valid & eval_cond(ce, flags_q);
   assign pc_src    = pc_s  & cond_ex;
   assign reg_write = reg_w & cond_ex;
   assign mem_write = mem_w & cond_ex;

   always_comb begin
      flags_d = flags_q;
      if (flag_w[1] && cond_ex) flags_d[3:2] = alu_flags[3:2];
      if (flag_w[0] && cond_ex) flags_d[1:0] = alu_flags[1:0];
   end

   assign cond_ex_d = instr_valid ? cond_ex : cond_ex_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q   <= 4'd0;
         cond_ex_q <= 1'b0;
      end else begin
         flags_q   <= flags_d;
         cond_ex_q <= cond_ex_d;
      end
   end

   assign flags = flags_q;

endmodule
